// File: rtl/mcg_pkg.sv
// Shared types and helpers for the multi-channel clock gater.
// Channel FSM encoding and drain counter sizing.
package mcg_pkg;

   typedef enum logic [1:0] {
      CG_IDLE,
      CG_ACTIVE,
      CG_DRAIN
   } cg_state_t;

   // Drain counter width; a zero hold-off still needs one bit.
   function automatic int cnt_width(input int idle_cycles);
      return (idle_cycles > 0) ? $clog2(idle_cycles + 1) : 1;
   endfunction

endpackage

// File: rtl/clock_gate_cell.sv
// Behavioural latch-plus-AND integrated clock gate.
// Replace with the library ICG cell for synthesis.
module clock_gate_cell (
   input  logic clk,
   input  logic en,
   input  logic test_en,
   output logic gclk
);

   logic en_lat;

   // Enable is captured while clk is low so gclk cannot glitch.
   always_latch begin
      if (!clk) en_lat = en | test_en;
   end

   assign gclk = clk & en_lat;

endmodule

// File: rtl/multi_ch_clock_gater.sv
// Multi-channel start/finish clock-gating controller.
// Per-channel FSM, drain hold-off and gated-cycle statistics.
module multi_ch_clock_gater
   import mcg_pkg::*;
#(
   parameter int NUM_CH      = 4,
   parameter int IDLE_CYCLES = 8,
   parameter int STAT_W      = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NUM_CH-1:0]        start,
   input  logic [NUM_CH-1:0]        finish,
   input  logic                     force_on,
   input  logic                     test_en,
   input  logic                     clr_stats,
   output logic [NUM_CH-1:0]        gclk,
   output logic [NUM_CH-1:0]        ch_active,
   output logic                     all_idle,
   output logic [NUM_CH*STAT_W-1:0] gated_cnt
);

   localparam int CNT_W = cnt_width(IDLE_CYCLES);
   localparam logic [CNT_W-1:0] LOAD =
      CNT_W'((IDLE_CYCLES > 0) ? IDLE_CYCLES - 1 : 0);
   localparam bit NO_DRAIN = (IDLE_CYCLES == 0);

   logic [NUM_CH-1:0] en;
   logic [NUM_CH-1:0] idle_nxt;

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch

      cg_state_t         state;
      cg_state_t         state_nxt;
      logic [CNT_W-1:0]  cnt;
      logic [CNT_W-1:0]  cnt_nxt;
      logic              act_q;
      logic [STAT_W-1:0] stat;

      // Next-state and drain counter; start always wins over finish.
      always_comb begin
         state_nxt = state;
         cnt_nxt   = cnt;
         unique case (state)
            CG_IDLE: begin
               if (start[i]) state_nxt = CG_ACTIVE;
            end
            CG_ACTIVE: begin
               if (!start[i] && finish[i]) begin
                  if (NO_DRAIN) begin
                     state_nxt = CG_IDLE;
                  end else begin
                     state_nxt = CG_DRAIN;
                     cnt_nxt   = LOAD;
                  end
               end
            end
            CG_DRAIN: begin
               if (start[i]) begin
                  state_nxt = CG_ACTIVE;
                  cnt_nxt   = '0;
               end else if (cnt == '0) begin
                  state_nxt = CG_IDLE;
               end else begin
                  cnt_nxt = cnt - 1'b1;
               end
            end
            default: begin
               state_nxt = CG_IDLE;
               cnt_nxt   = '0;
            end
         endcase
      end

      // State, counter and registered activity flag.
      always_ff @(posedge clk) begin
         if (rst) begin
            state <= CG_IDLE;
            cnt   <= '0;
            act_q <= 1'b0;
         end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            act_q <= (state_nxt != CG_IDLE);
         end
      end

      // Saturating count of edges where this channel was gated.
      always_ff @(posedge clk) begin
         if (rst || clr_stats) begin
            stat <= '0;
         end else if (!en[i] && (stat != '1)) begin
            stat <= stat + 1'b1;
         end
      end

      assign en[i] = rst | test_en | force_on | start[i]
                   | (state != CG_IDLE);
      assign idle_nxt[i] = (state_nxt == CG_IDLE);
      assign ch_active[i] = act_q;
      assign gated_cnt[i*STAT_W +: STAT_W] = stat;

      clock_gate_cell u_cg (
         .clk     (clk),
         .en      (en[i]),
         .test_en (test_en),
         .gclk    (gclk[i])
      );

   end

   // Global idle flag tracks the channel next-states.
   always_ff @(posedge clk) begin
      if (rst) all_idle <= 1'b1;
      else     all_idle <= &idle_nxt;
   end

endmodule
